shift_scheduler: RTL and testbench
==================================

// Module: shift_scheduler
// PURPOSE
//   Round-robin scheduler that shares one 32-bit shifter datapath (SLL/SRL/SRA) between NUM_REQ requesters.
//   Each requester uses a valid/ready handshake. The block arbitrates, drives the shifter with the winner's
//   op/amount/data, and registers the result with requester ID behind a backpressured response port.
//   Sits between ALU issue logic and the shifter; throughput is 1 operation/cycle.
// PARAMETERS
//   NUM_REQ   4    number of requesters (2..8)
//   ID_W      2    width of rsp_id; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//   clk        in   1          clock, all state updates on rising edge
//   rst_n      in   1          synchronous reset, active-low
//   req_valid  in   NUM_REQ    per-requester request valid
//   req_op     in   2*NUM_REQ  per-requester op, slice [2i+1:2i]: 00=SLL 10=SRL 11=SRA 01=illegal
//   req_amt    in   5*NUM_REQ  per-requester shift amount, slice [5i+4:5i]
//   req_data   in   32*NUM_REQ per-requester operand, slice [32i+31:32i]
//   req_ready  out  NUM_REQ    one-hot grant; a request is accepted when req_valid[i] & req_ready[i]
//   rsp_valid  out  1          response valid
//   rsp_ready  in   1          response consumer ready
//   rsp_id     out  ID_W       index of requester that produced rsp_data
//   rsp_data   out  32         shift result
//   rsp_err    out  1          illegal op flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): state=EMPTY, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, rr_ptr=0.
//     Reset mid-operation discards the held response; no response is produced for it.
//   - FSM, 2 states:
//     EMPTY: output register holds nothing. Accept allowed. On accept -> FULL.
//     FULL: rsp_valid=1. If rsp_ready & accept -> FULL with new result.
//           If rsp_ready & no accept -> EMPTY. If !rsp_ready -> FULL, outputs held stable.
//   - can_accept = (state==EMPTY) | rsp_ready. This is combinational from rsp_ready to req_ready, and is permitted.
//   - Arbitration: combinational round-robin over req_valid, starting at rr_ptr.
//     req_ready = one-hot winner when can_accept, else all 0. req_ready never asserts for a non-valid requester.
//   - On accept of requester i: rr_ptr <= (i+1) mod NUM_REQ. rr_ptr is unchanged otherwise.
//   - Latency: a request accepted at edge N has its result on rsp_data/rsp_id/rsp_valid after edge N (1 cycle).
//   - Requesters must hold op/amt/data stable while valid & !ready. The block does not store unaccepted requests.
//   - Shift semantics, with amt 0..31:
//     SLL = data << amt, zero fill.
//     SRL = data >> amt, zero fill.
//     SRA = data >> amt, fill with data[31].
//     amt=0 returns data unchanged for all ops.
//   - Shift datapath is purely combinational in the same cycle as arbitration.
//     SLL is implemented by bit-reversing around a right shifter; the result must equal the plain left shift.
//   - No requests valid -> no grant, rr_ptr unchanged, the FSM drains per the rules above.
// CONFIGURATION
//   SHIFT_SCHED_ILLEGAL_EN defined:
//     - op 01 accepted normally.
//     - Response has rsp_data=32'h0, rsp_err=1.
//     - rsp_err=0 for legal ops.
//   SHIFT_SCHED_ILLEGAL_EN undefined:
//     - op 01 executes as SLL.
//     - rsp_err tied 0.
//     - No extra logic.
// TESTING
//   1 Reset: rst_n=0 two cycles with all req_valid=1 -> rsp_valid=0, req_ready=0 during reset; after release first grant is req 0.
//   2 Single ops on req 1:
//     SLL amt=4 data=32'h0000_00F1 -> 32'h0000_0F10.
//     SRL amt=8 data=32'h8000_0000 -> 32'h0080_0000.
//     SRA amt=8 data=32'h8000_0000 -> 32'hFF80_0000.
//     All have rsp_id=1 one cycle after accept.
//   3 Round-robin: all 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence matches.
//   4 Backpressure: rsp_ready=0 for 5 cycles while FULL -> req_ready=0, rsp_* stable.
//     Raising rsp_ready with pending request -> same-cycle handoff, no bubble, no loss.
//   5 Boundaries: amt=0 and amt=31 for all ops on data=32'hA5A5_A5A5.
//     amt=31: SLL -> 32'h8000_0000, SRL -> 32'h1, SRA -> 32'hFFFF_FFFF.
//   6 Illegal op 01, data=32'h1234_5678 amt=3:
//     with SHIFT_SCHED_ILLEGAL_EN -> rsp_data=0, rsp_err=1.
//     without -> rsp_data=32'h91A2_B3C0, rsp_err=0.
//     Also assert reset mid-FULL drops the response.

Source files
------------

// File: rtl/shift_scheduler_if.sv
// Request/response bundle for shift_scheduler: NUM_REQ flat request lanes and one backpressured response.
interface shift_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [2*NUM_REQ-1:0]  req_op;
    logic [5*NUM_REQ-1:0]  req_amt;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_op, req_amt, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_amt, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/shift_scheduler.sv
// Round-robin arbiter sharing one 32-bit SLL/SRL/SRA shifter between NUM_REQ requesters, 1-deep response register.
// Optional SHIFT_SCHED_ILLEGAL_EN: op 01 returns zero data with rsp_err set; otherwise op 01 behaves as SLL.
module shift_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_scheduler_if.slave   bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_next;

    logic [ID_W-1:0]              rr_ptr;
    logic [ID_W-1:0]              win;
    logic [ID_W-1:0]              idx;
    logic                         any_valid;
    logic                         can_accept;
    logic                         accept;

    logic [NUM_REQ-1:0][1:0]      op_arr;
    logic [NUM_REQ-1:0][4:0]      amt_arr;
    logic [NUM_REQ-1:0][31:0]     data_arr;

    logic [1:0]                   sel_op;
    logic [4:0]                   sel_amt;
    logic [31:0]                  sel_data;
    logic                         is_left;
    logic                         is_arith;
    logic [31:0]                  sh_in;
    logic [31:0]                  sh_out;
    logic [31:0]                  shift_res;
    logic [31:0]                  result;

    logic [ID_W-1:0]              rsp_id_q;
    logic [31:0]                  rsp_data_q;

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int b = 0; b < 32; b++) r[b] = v[31-b];
        return r;
    endfunction

    assign op_arr   = bus.req_op;
    assign amt_arr  = bus.req_amt;
    assign data_arr = bus.req_data;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        any_valid = 1'b0;
        win       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_valid && bus.req_valid[idx]) begin
                any_valid = 1'b1;
                win       = idx;
            end
        end
    end

    assign can_accept    = rst_n & ((state == EMPTY) | bus.rsp_ready);
    assign accept        = can_accept & any_valid;
    assign bus.req_ready = accept ? (NUM_REQ'(1) << win) : '0;

    assign sel_op   = op_arr[win];
    assign sel_amt  = amt_arr[win];
    assign sel_data = data_arr[win];

`ifdef SHIFT_SCHED_ILLEGAL_EN
    assign is_left = (sel_op == 2'b00);
`else
    assign is_left = ~sel_op[1];
`endif
    assign is_arith = (sel_op == 2'b11);

    // Left shifts reuse the right shifter by reversing bits on the way in and out.
    assign sh_in     = is_left ? bitrev(sel_data) : sel_data;
    assign sh_out    = is_arith ? 32'($signed(sh_in) >>> sel_amt) : (sh_in >> sel_amt);
    assign shift_res = is_left ? bitrev(sh_out) : sh_out;

`ifdef SHIFT_SCHED_ILLEGAL_EN
    logic rsp_err_q;
    assign result = (sel_op == 2'b01) ? 32'h0 : shift_res;

    always_ff @(posedge clk) begin
        if (!rst_n)      rsp_err_q <= 1'b0;
        else if (accept) rsp_err_q <= (sel_op == 2'b01);
    end
    assign bus.rsp_err = rsp_err_q;
`else
    assign result      = shift_res;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (bus.rsp_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else if (accept) begin
            rr_ptr     <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            rsp_id_q   <= win;
            rsp_data_q <= result;
        end
    end

    assign bus.rsp_valid = (state == FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_shift_scheduler.sv
// Directed and randomized checks of shift_scheduler against a cycle-level queue/arithmetic reference model.
module tb_shift_scheduler;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_scheduler_if #(.NUM_REQ(N), .ID_W(IW)) bus();
    shift_scheduler #(.NUM_REQ(N), .ID_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    // {err, data} from the architectural shift rules.
    function automatic logic [32:0] ref_shift(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] d);
        logic [31:0] fill;
        fill = d[31] ? ~(32'hFFFF_FFFF >> amt) : 32'h0;
        case (op)
            2'b00: return {1'b0, d << amt};
            2'b10: return {1'b0, d >> amt};
            2'b11: return {1'b0, (d >> amt) | fill};
`ifdef SHIFT_SCHED_ILLEGAL_EN
            default: return {1'b1, 32'h0};
`else
            default: return {1'b0, d << amt};
`endif
        endcase
    endfunction

    task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [4:0] amt, input logic [31:0] d);
        bus.req_valid[i]        = v;
        bus.req_op[2*i +: 2]    = op;
        bus.req_amt[5*i +: 5]   = amt;
        bus.req_data[32*i +: 32] = d;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_amt   = '0;
        bus.req_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_reqs();
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b00, 5'(i + 1), 32'(i * 256));
        #1;
        total++;
        if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready_a got=%b exp=0000", bus.req_ready); end
        @(negedge clk); #1;
        total++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req_ready} !== '0) begin
            bad++; $display("FAIL reset_state got v=%b id=%0d d=%h e=%b rdy=%b exp all zero",
                            bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b exp=0001", bus.req_ready); end
        clear_reqs();
        @(negedge clk); #1;
        total++;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_no_accept got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_single_ops();
        logic [1:0]  ops[3]  = '{2'b00, 2'b10, 2'b11};
        logic [4:0]  amts[3] = '{5'd4, 5'd8, 5'd8};
        logic [31:0] din[3]  = '{32'h0000_00F1, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] exps[3] = '{32'h0000_0F10, 32'h0080_0000, 32'hFF80_0000};
        bus.rsp_ready = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) set_req(1, 1'b1, ops[k], amts[k], din[k]);
            else       clear_reqs();
            #1;
            if (k < 3) begin
                total++;
                if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL single_grant%0d got=%b exp=0010", k, bus.req_ready); end
            end
            if (k > 0) begin
                total++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== exps[k-1]) begin
                    bad++; $display("FAIL single_rsp%0d got v=%b id=%0d d=%h exp v=1 id=1 d=%h",
                                    k - 1, bus.rsp_valid, bus.rsp_id, bus.rsp_data, exps[k-1]);
                end
            end
        end
        @(negedge clk); #1;
        total++;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  lop[3] = '{2'b00, 2'b10, 2'b11};
        logic [1:0]  op[N];
        logic [4:0]  amt[N];
        logic [31:0] d[N];
        logic [32:0] r;
        int          p;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            op[i]  = lop[$urandom_range(0, 2)];
            amt[i] = 5'($urandom_range(0, 31));
            d[i]   = $urandom;
            set_req(i, 1'b1, op[i], amt[i], d[i]);
        end
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            total++;
            if (bus.req_ready !== (4'b0001 << (k % N))) begin
                bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, bus.req_ready, 4'b0001 << (k % N));
            end
            if (k > 0) begin
                p = (k - 1) % N;
                r = ref_shift(op[p], amt[p], d[p]);
                total++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IW'(p) || bus.rsp_data !== r[31:0]) begin
                    bad++; $display("FAIL rr_rsp%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                                    k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, p, r[31:0]);
                end
            end
        end
        clear_reqs();
    endtask

    task automatic test_backpressure();
        logic [31:0] d0 = 32'hDEAD_BEEF;
        logic [31:0] d2 = 32'h0F0F_1234;
        logic [32:0] e0 = ref_shift(2'b10, 5'd3, d0);
        logic [32:0] e2 = ref_shift(2'b00, 5'd5, d2);
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 2'b10, 5'd3, d0);
        #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL bp_first got=%b exp=0001", bus.req_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.req_valid[0] = 1'b0;
                set_req(2, 1'b1, 2'b00, 5'd5, d2);
                bus.rsp_ready = 1'b0;
            end
            #1;
            total++;
            if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== e0[31:0]) begin
                bad++; $display("FAIL bp_hold%0d got rdy=%b v=%b id=%0d d=%h exp rdy=0000 v=1 id=0 d=%h",
                                c, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, e0[31:0]);
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 4'b0100 || bus.rsp_id !== 2'd0 || bus.rsp_data !== e0[31:0]) begin
            bad++; $display("FAIL bp_handoff got rdy=%b id=%0d d=%h exp rdy=0100 id=0 d=%h",
                            bus.req_ready, bus.rsp_id, bus.rsp_data, e0[31:0]);
        end
        @(negedge clk);
        clear_reqs();
        #1;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== e2[31:0]) begin
            bad++; $display("FAIL bp_next got v=%b id=%0d d=%h exp v=1 id=2 d=%h",
                            bus.rsp_valid, bus.rsp_id, bus.rsp_data, e2[31:0]);
        end
        @(negedge clk); #1;
        total++;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_boundaries();
        logic [1:0]  ops[6]  = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11};
        logic [4:0]  amts[6] = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31};
        logic [31:0] exps[6] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5,
                                 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        bus.rsp_ready = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k < 6) set_req(3, 1'b1, ops[k], amts[k], 32'hA5A5_A5A5);
            else       clear_reqs();
            #1;
            if (k > 0) begin
                total++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_data !== exps[k-1] || bus.rsp_err !== 1'b0) begin
                    bad++; $display("FAIL bound%0d got v=%b id=%0d d=%h e=%b exp v=1 id=3 d=%h e=0",
                                    k - 1, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, exps[k-1]);
                end
            end
        end
    endtask

    task automatic test_illegal();
`ifdef SHIFT_SCHED_ILLEGAL_EN
        logic [31:0] exp_d = 32'h0;
        logic        exp_e = 1'b1;
`else
        logic [31:0] exp_d = 32'h91A2_B3C0;
        logic        exp_e = 1'b0;
`endif
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        set_req(2, 1'b1, 2'b01, 5'd3, 32'h1234_5678);
        #1;
        total++;
        if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL illegal_grant got=%b exp=0100", bus.req_ready); end
        @(negedge clk);
        clear_reqs();
        #1;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.rsp_err !== exp_e) begin
            bad++; $display("FAIL illegal_rsp got v=%b d=%h e=%b exp v=1 d=%h e=%b",
                            bus.rsp_valid, bus.rsp_data, bus.rsp_err, exp_d, exp_e);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        set_req(1, 1'b1, 2'b00, 5'd1, 32'h0000_0003);
        #1;
        total++;
        if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL midrst_grant got=%b exp=0010", bus.req_ready); end
        @(negedge clk);
        clear_reqs();
        #1;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_0006) begin
            bad++; $display("FAIL midrst_full got v=%b d=%h exp v=1 d=00000006", bus.rsp_valid, bus.rsp_data);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0) begin
            bad++; $display("FAIL midrst_drop got v=%b d=%h exp v=0 d=0", bus.rsp_valid, bus.rsp_data);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_after got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_random();
        logic        p_v[N];
        logic [1:0]  p_op[N];
        logic [4:0]  p_amt[N];
        logic [31:0] p_d[N];
        int          m_rr = 0;
        logic        m_vld = 1'b0;
        int          m_id = 0;
        logic [31:0] m_data = '0;
        logic        m_err = 1'b0;
        int          w;
        int          j;
        logic        can;
        logic [N-1:0] exp_grant;
        logic [32:0] r;
        do_reset();
        for (int i = 0; i < N; i++) begin
            p_v[i] = 1'b0; p_op[i] = '0; p_amt[i] = '0; p_d[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!p_v[i] && $urandom_range(0, 2) == 0) begin
                    p_v[i]   = 1'b1;
                    p_op[i]  = 2'($urandom_range(0, 3));
                    p_amt[i] = 5'($urandom_range(0, 31));
                    p_d[i]   = $urandom;
                end
                set_req(i, p_v[i], p_op[i], p_amt[i], p_d[i]);
            end
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            #1;
            w = -1;
            for (int k = 0; k < N; k++) begin
                j = (m_rr + k) % N;
                if (w < 0 && p_v[j]) w = j;
            end
            can = !m_vld || bus.rsp_ready;
            exp_grant = (can && w >= 0) ? (N'(1) << w) : '0;
            total++;
            if (bus.req_ready !== exp_grant) begin
                bad++; $display("FAIL rand_grant c%0d got=%b exp=%b", cyc, bus.req_ready, exp_grant);
            end
            total++;
            if (bus.rsp_valid !== m_vld) begin
                bad++; $display("FAIL rand_valid c%0d got=%b exp=%b", cyc, bus.rsp_valid, m_vld);
            end
            if (m_vld) begin
                total++;
                if (bus.rsp_id !== IW'(m_id) || bus.rsp_data !== m_data || bus.rsp_err !== m_err) begin
                    bad++; $display("FAIL rand_rsp c%0d got id=%0d d=%h e=%b exp id=%0d d=%h e=%b",
                                    cyc, bus.rsp_id, bus.rsp_data, bus.rsp_err, m_id, m_data, m_err);
                end
            end
            if (exp_grant != '0) begin
                r      = ref_shift(p_op[w], p_amt[w], p_d[w]);
                m_vld  = 1'b1;
                m_id   = w;
                m_data = r[31:0];
                m_err  = r[32];
                p_v[w] = 1'b0;
                m_rr   = (w + 1) % N;
            end else if (m_vld && bus.rsp_ready) begin
                m_vld = 1'b0;
            end
        end
        @(negedge clk);
        clear_reqs();
        bus.rsp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_reqs();
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single_ops();
        test_round_robin();
        test_backpressure();
        test_boundaries();
        test_illegal();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
